// File: rtl/dnn_pkg.sv
// Shared definitions for the drain/requantise/pack stage: FSM encoding and default widths.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAPT = 2'd2,
        PUSH = 2'd3
    } state_t;

    localparam int B_DEF  = 24;
    localparam int N_DEF  = 40;
    localparam int OB_DEF = 8;

endpackage

// File: rtl/drain_relu_pack_requant_sat.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, saturate to OB bits.
// Rounding mode is chosen by DRAIN_ROUND_EN (defined: round half up, undefined: floor).
module requant_sat #(
    parameter int B     = 24,
    parameter int OB    = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [B-1:0]  x,
    input  logic                 relu,
    output logic signed [OB-1:0] y
);

`ifdef DRAIN_ROUND_EN
    localparam logic signed [B:0] RND = (B+1)'(1 << (SHIFT-1));
`else
    localparam logic signed [B:0] RND = '0;
`endif
    localparam logic signed [B:0] HI = (B+1)'((1 << (OB-1)) - 1);
    localparam logic signed [B:0] LO = -HI - (B+1)'(1);

    logic signed [B:0] sx;
    logic signed [B:0] sum;
    logic signed [B:0] v;
    logic signed [B:0] vr;

    // One guard bit so adding RND to the most positive input cannot wrap.
    always_comb begin
        sx  = {x[B-1], x};
        sum = sx + RND;
        v   = sum >>> SHIFT;
        vr  = (relu && (v < 0)) ? '0 : v;
        if (vr > HI) begin
            y = HI[OB-1:0];
        end else if (vr < LO) begin
            y = LO[OB-1:0];
        end else begin
            y = vr[OB-1:0];
        end
    end

endmodule

// File: rtl/drain_relu_pack.sv
// Drains N shiftregout results pairwise, requantises each lane and pushes packed words
// to the output buffer over valid/ready. Rounding is selected by the DRAIN_ROUND_EN macro.
module drain_relu_pack
    import dnn_pkg::*;
#(
    parameter int B     = B_DEF,
    parameter int N     = N_DEF,
    parameter int AW    = 6,
    parameter int OB    = OB_DEF,
    parameter int SHIFT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                relu_en,
    output logic [AW-1:0]       addr1,
    output logic [AW-1:0]       addr2,
    input  logic signed [B-1:0] out1,
    input  logic signed [B-1:0] out2,
    output logic [2*OB-1:0]     ob_data,
    output logic [AW-2:0]       ob_addr,
    output logic                ob_valid,
    input  logic                ob_ready,
    output logic                busy,
    output logic                done,
    output state_t              state_dbg
);

    // Handshake: a word transfers on every rising edge where ob_valid && ob_ready;
    // ob_data/ob_addr never change while ob_valid is high and ob_ready is low.

    localparam logic [AW-2:0] K_LAST = (AW-1)'(N/2 - 1);

    state_t              state;
    state_t              state_n;
    logic [AW-2:0]       k;
    logic [AW-2:0]       k_inc;
    logic                relu_q;
    logic                last;
    logic signed [OB-1:0] y0;
    logic signed [OB-1:0] y1;

    assign k_inc     = k + 1'b1;
    assign last      = (k == K_LAST);
    assign ob_valid  = (state == PUSH);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    requant_sat #(.B(B), .OB(OB), .SHIFT(SHIFT)) u_rq0 (
        .x    (out1),
        .relu (relu_q),
        .y    (y0)
    );

    requant_sat #(.B(B), .OB(OB), .SHIFT(SHIFT)) u_rq1 (
        .x    (out2),
        .relu (relu_q),
        .y    (y1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ADDR;
            ADDR:    state_n = CAPT;
            CAPT:    state_n = PUSH;
            PUSH:    if (ob_ready) state_n = last ? IDLE : ADDR;
            default: state_n = IDLE;
        endcase
    end

    // Addresses are loaded on entry to ADDR so shiftregout data lands during CAPT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            relu_q  <= 1'b0;
            addr1   <= '0;
            addr2   <= '0;
            ob_data <= '0;
            ob_addr <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k      <= '0;
                        relu_q <= relu_en;
                        addr1  <= {{(AW-1){1'b0}}, 1'b0};
                        addr2  <= {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                CAPT: begin
                    ob_data <= {y1, y0};
                    ob_addr <= k;
                end
                PUSH: begin
                    if (ob_ready) begin
                        if (last) begin
                            done <= 1'b1;
                        end else begin
                            k     <= k_inc;
                            addr1 <= {k_inc, 1'b0};
                            addr2 <= {k_inc, 1'b1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_drain_relu_pack.sv
// Self-checking bench for drain_relu_pack: shiftregout memory model, requantisation
// reference computed with integer arithmetic, expected-word queue and latency checks.
module tb_drain_relu_pack;
    import dnn_pkg::*;

    localparam int B     = 24;
    localparam int N     = 40;
    localparam int AW    = 6;
    localparam int OB    = 8;
    localparam int SHIFT = 4;
`ifdef DRAIN_ROUND_EN
    localparam longint RND_REF = 8;
    localparam logic [15:0] NEG_W0 = 16'h80FA;
    localparam logic [15:0] POS_W0 = 16'h0D06;
`else
    localparam longint RND_REF = 0;
    localparam logic [15:0] NEG_W0 = 16'h80F9;
    localparam logic [15:0] POS_W0 = 16'h0C06;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                relu_en = 1'b0;
    logic [AW-1:0]       addr1;
    logic [AW-1:0]       addr2;
    logic signed [B-1:0] out1 = '0;
    logic signed [B-1:0] out2 = '0;
    logic [2*OB-1:0]     ob_data;
    logic [AW-2:0]       ob_addr;
    logic                ob_valid;
    logic                ob_ready = 1'b0;
    logic                busy;
    logic                done;
    state_t              state_dbg;

    logic signed [B-1:0] mem [N];
    logic [2*OB-1:0]     exp_q [$];
    int                  passed_cnt = 0;
    int                  total_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    drain_relu_pack #(.B(B), .N(N), .AW(AW), .OB(OB), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .addr1     (addr1),
        .addr2     (addr2),
        .out1      (out1),
        .out2      (out2),
        .ob_data   (ob_data),
        .ob_addr   (ob_addr),
        .ob_valid  (ob_valid),
        .ob_ready  (ob_ready),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // shiftregout model: registered read, one clock of latency
    always @(posedge clk) begin
        out1 <= (int'(addr1) < N) ? mem[addr1] : '0;
        out2 <= (int'(addr2) < N) ? mem[addr2] : '0;
    end

    // ---------------- reference model ----------------
    function automatic logic [OB-1:0] ref_rq(input longint x, input bit relu);
        longint v;
        longint q;
        longint div;
        div = longint'(1) << SHIFT;
        v = x + RND_REF;
        if (v >= 0) q = v / div;
        else        q = -((-v + div - 1) / div);
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return OB'(q);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_ramp();
        for (int i = 0; i < N; i++) mem[i] = B'(100 * (i + 1));
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) mem[i] = B'($urandom_range(0, (1 << B) - 1));
            else mem[i] = B'(int'($urandom_range(0, 8000)) - 4000);
        end
    endtask

    task automatic run_drain(input bit relu, input int stall_pair, input int stall_len,
                             input int abort_pair, output int cycles,
                             output logic [15:0] w0, output logic [15:0] w1);
        int exp_addr;
        int stall_left;
        bit held;
        bit fin;
        bit saw_done;
        logic [15:0] held_d;
        logic [AW-2:0] held_a;
        logic [15:0] e;
        exp_q.delete();
        for (int i = 0; i < N / 2; i++)
            exp_q.push_back({ref_rq(longint'(mem[2*i+1]), relu), ref_rq(longint'(mem[2*i]), relu)});
        w0 = '0;
        w1 = '0;
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        relu_en = ~relu;
        cycles = 0;
        exp_addr = 0;
        stall_left = stall_len;
        held = 0;
        fin = 0;
        held_d = '0;
        held_a = '0;
        while (!fin && cycles < 500) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (abort_pair >= 0 && ob_valid && int'(ob_addr) == abort_pair) begin
                rst = 1'b1;
                #1;
                check("abort_valid", 32'(ob_valid), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_addr", {20'(addr1), 12'(addr2)}, 0);
                @(negedge clk);
                rst = 1'b0;
                saw_done = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (done || busy || ob_valid) saw_done = 1;
                end
                check("abort_quiet", 32'(saw_done), 0);
                fin = 1;
            end else if (done) begin
                fin = 1;
                check("queue_empty", 32'(exp_q.size()), 0);
                check("done_addr_cnt", 32'(exp_addr), N / 2);
                @(negedge clk);
                check("done_one_cycle", {31'(busy), done}, 0);
            end else if (ob_valid) begin
                if (int'(ob_addr) == stall_pair && stall_left > 0) begin
                    ob_ready = 1'b0;
                    stall_left--;
                end else begin
                    ob_ready = 1'b1;
                end
                if (held) begin
                    check("stall_data", 32'(ob_data), 32'(held_d));
                    check("stall_addr", 32'(ob_addr), 32'(held_a));
                end
                if (ob_ready) begin
                    held = 0;
                    check("ob_addr", 32'(ob_addr), 32'(exp_addr));
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    check("ob_data", 32'(ob_data), 32'(e));
                    if (exp_addr == 0) w0 = ob_data;
                    if (exp_addr == 1) w1 = ob_data;
                    exp_addr++;
                end else begin
                    held = 1;
                    held_d = ob_data;
                    held_a = ob_addr;
                end
            end else begin
                ob_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!fin) check("timeout", 1, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        logic [15:0] w0;
        logic [15:0] w1;
        for (int i = 0; i < N; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(ob_valid), 0);
        check("rst_busy_done", {31'(busy), done}, 0);
        check("rst_addr", {20'(addr1), 12'(addr2)}, 0);
        check("rst_ob", {16'(ob_data), 16'(ob_addr)}, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ramp, relu off, no backpressure
        fill_ramp();
        run_drain(1'b0, -1, 0, -1, cyc, w0, w1);
        check("ramp_latency", 32'(cyc), 60);
        check("ramp_word0", 32'(w0), 32'(POS_W0));

        // signed boundaries in pairs 0 and 1
        fill_random();
        mem[0] = -B'(100);
        mem[1] = {1'b1, {(B-1){1'b0}}};
        mem[2] = {1'b0, {(B-1){1'b1}}};
        mem[3] = '0;
        run_drain(1'b0, -1, 0, -1, cyc, w0, w1);
        check("neg_word0", 32'(w0), 32'(NEG_W0));
        check("sat_word1", 32'(w1), 32'h007F);
        run_drain(1'b1, -1, 0, -1, cyc, w0, w1);
        check("relu_word0", 32'(w0), 0);
        check("relu_word1", 32'(w1), 32'h007F);

        // random data with backpressure at pair 3
        fill_random();
        run_drain(1'b1, 3, 5, -1, cyc, w0, w1);
        check("stall_latency", 32'(cyc), 65);

        // reset in the middle of pair 7, then a clean drain
        fill_random();
        run_drain(1'b0, -1, 0, 7, cyc, w0, w1);
        fill_random();
        run_drain(1'b0, -1, 0, -1, cyc, w0, w1);
        check("post_rst_latency", 32'(cyc), 60);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/drain_relu_pack.md
Name: drain_relu_pack

Overview:
- Downstream stage of shiftregout: sequences the two shiftregout read addresses (addr1/addr2) across all N perceptron results and captures out1/out2.
- Requantises each B-bit accumulator to OB bits: arithmetic right shift, optional ReLU, saturation.
- Packs each result pair into one word and pushes it to the output buffer over a valid/ready handshake.
- Asserts done once all N results have been written.

Parameters:
- B, 24, accumulator width of each shiftregout lane (out1/out2).
- N, 40, number of perceptron results to drain; must be even and at most 2^AW.
- AW, 6, address width of addr1/addr2.
- OB, 8, output width per lane after requantisation.
- SHIFT, 4, right-shift amount for requantisation; 1 <= SHIFT < B.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a drain when IDLE.
- relu_en  in  1  1 = clamp negative results to 0; sampled on the accepted start.
- addr1  out  AW  shiftregout read address, lane 0.
- addr2  out  AW  shiftregout read address, lane 1.
- out1  in  B  shiftregout data for addr1, signed, valid one clk after the address.
- out2  in  B  shiftregout data for addr2, signed, valid one clk after the address.
- ob_data  out  2*OB  packed pair: [OB-1:0] = lane 0, [2*OB-1:OB] = lane 1.
- ob_addr  out  AW-1  pair index 0..N/2-1.
- ob_valid  out  1  ob_data/ob_addr valid.
- ob_ready  in  1  output buffer accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - state = IDLE; pair index k = 0.
  - addr1, addr2, ob_data, ob_addr, ob_valid, busy, done = 0.
  - No further push is issued.
- FSM states IDLE, ADDR, CAPT, PUSH.
  - IDLE: start=1 -> ADDR with k=0; relu_en latched. start in any other state is ignored.
  - ADDR: drive addr1 = 2k, addr2 = 2k+1; -> CAPT. Addresses are registered and held through CAPT.
  - CAPT: register requant(out1) and requant(out2) into ob_data; ob_addr = k; -> PUSH.
  - PUSH: ob_valid=1. ob_data and ob_addr are held stable until ob_ready=1.
    - Handshake (ob_valid && ob_ready) on a non-final pair -> ADDR with k+1.
    - Handshake on the final pair (k = N/2-1) -> IDLE with done=1 for exactly one cycle.
  - ob_valid drops in the cycle after the handshake.
- Timing: 3 clocks per pair when ob_ready is held high. For N=40, done is high in the cycle following the 60th rising edge after the edge that sampled start.
- Requantisation (lane-independent), computed at width B+1 so rounding cannot overflow:
  - v = (x + RND) >>> SHIFT, where RND is set by the Optional Feature.
  - If the latched relu_en=1 and v < 0, then v = 0.
  - Saturate v to [-2^(OB-1), 2^(OB-1)-1].
- Boundary conditions:
  - ob_ready stuck low stalls indefinitely in PUSH; no data is lost.
  - ob_ready high in the same cycle ob_valid first rises completes the handshake in that cycle.
  - x = -2^(B-1) passes through without wrap and saturates to -2^(OB-1), or to 0 under ReLU.

Optional Feature:
- Macro DRAIN_ROUND_EN.
- Defined: RND = 2^(SHIFT-1), i.e. round half up.
- Undefined: RND = 0, i.e. floor truncation.
- All other behaviour and timing are identical in both builds.

Decomposition:
- Shared package dnn_pkg holds:
  - FSM state encoding constants (IDLE, ADDR, CAPT, PUSH).
  - Default widths B_DEF=24, N_DEF=40, OB_DEF=8.
- One sub-module, requant_sat (params B, OB, SHIFT; ports x, relu, y): purely combinational, instantiated twice, once per lane.

Test Plan:
- All cases use defaults (SHIFT=4, OB=8) with a shiftregout-style model, 1-clk read latency.
- Drain, ROUND_EN on: lane i = 100·(i+1), ob_ready=1, start -> 20 words; ob_addr 0..19; word0 = {13, 6} (200→13, 100→6); words with lane input ≥ 2040 saturate to 127; done 60 clks after start.
- Truncation build: same stimulus -> word0 = {12, 6}.
- Negative lanes: x = -100, relu_en=0 -> -6 with rounding, -7 truncated; relu_en=1 -> 0 in both builds.
- Extreme: x = -2^23, relu_en=0 -> -128 with no wrap.
- Backpressure: hold ob_ready=0 for 5 clks at pair 3 -> ob_data/ob_addr stable, no skipped or duplicate ob_addr; total latency grows by exactly 5.
- Reset mid-drain at pair 7: asserting rst clears ob_valid, busy and addr immediately; no done pulse; a fresh start then drains again from ob_addr 0.
